// File: rtl/poly_eval.sv
// rtl/poly_eval.sv - sequential evaluator of a*a + b*c with BCD and 7-segment outputs
//
// Ports:
//   CLOCK_50  in   sole clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   evaluation request, sampled only in IDLE
//   a, b, c   in   W-bit unsigned operands, captured on the accepting edge
//   busy      out  high whenever the FSM is not in IDLE
//   done      out  one-cycle pulse while result/bcd/HEX hold a new value
//   result    out  2W+1-bit binary a*a + b*c
//   bcd       out  packed BCD of result, digit 0 in bits [3:0]
//   HEX       out  active-low 7-segment codes, digit 0 in bits [7:0], leading zeros blanked
module poly_eval #(
    parameter int W  = 3,
    parameter int ND = 3
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic [W-1:0]      c,
    output logic              busy,
    output logic              done,
    output logic [2*W:0]      result,
    output logic [4*ND-1:0]   bcd,
    output logic [8*ND-1:0]   HEX
);
    localparam int RW = 2*W + 1;
    localparam int DW = 4*ND + RW;
    localparam int CW = $clog2(RW + 2);

    typedef enum logic [2:0] {IDLE, MUL_A, MUL_B, ADD, BCD, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [W-1:0]        b_q, b_d, c_q, c_d;
    logic [2*W-1:0]      mcand_q, mcand_d;
    logic [W-1:0]        mplier_q, mplier_d;
    logic [2*W-1:0]      acc_q, acc_d;
    logic [2*W-1:0]      prod_a_q, prod_a_d;
    logic [RW-1:0]       sum_q, sum_d;
    logic [DW-1:0]       dd_q, dd_d;
    logic [RW-1:0]       result_q, result_d;
    logic [4*ND-1:0]     bcd_q, bcd_d;

    logic [2*W-1:0]      acc_step;
    logic [DW-1:0]       dd_adj;
    logic [3:0]          dig;
    logic                lead;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        b_d      = b_q;
        c_d      = c_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        prod_a_d = prod_a_q;
        sum_d    = sum_q;
        dd_d     = dd_q;
        result_d = result_q;
        bcd_d    = bcd_q;

        // One shift-add step: the multiplicand moves left, the multiplier right.
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

        // Double-dabble correction applied to the BCD field ahead of the shift.
        dd_adj = dd_q;
        for (int i = 0; i < ND; i++) begin
            if (dd_q[RW+4*i +: 4] >= 4'd5) begin
                dd_adj[RW+4*i +: 4] = dd_q[RW+4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{W{1'b0}}, a};
                    mplier_d = a;
                    acc_d    = '0;
                    b_d      = b;
                    c_d      = c;
                    cnt_d    = '0;
                    state_d  = MUL_A;
                end
            end
            MUL_A, MUL_B: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W-1)) begin
                    cnt_d = '0;
                    if (state_q == MUL_A) begin
                        prod_a_d = acc_step;
                        mcand_d  = {{W{1'b0}}, b_q};
                        mplier_d = c_q;
                        acc_d    = '0;
                        state_d  = MUL_B;
                    end else begin
                        state_d  = ADD;
                    end
                end
            end
            ADD: begin
                sum_d   = {1'b0, prod_a_q} + {1'b0, acc_q};
                dd_d    = {{(4*ND){1'b0}}, sum_d};
                cnt_d   = '0;
                state_d = BCD;
            end
            BCD: begin
                // RW shift cycles, then one cycle that commits the converted digits.
                if (cnt_q == CW'(RW)) begin
                    result_d = sum_q;
                    bcd_d    = dd_q[DW-1 -: 4*ND];
                    state_d  = DONE;
                end else begin
                    dd_d  = {dd_adj[DW-2:0], 1'b0};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            b_q      <= '0;
            c_q      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            prod_a_q <= '0;
            sum_q    <= '0;
            dd_q     <= '0;
            result_q <= '0;
            bcd_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            b_q      <= b_d;
            c_q      <= c_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            prod_a_q <= prod_a_d;
            sum_q    <= sum_d;
            dd_q     <= dd_d;
            result_q <= result_d;
            bcd_q    <= bcd_d;
        end
    end

    // Display decode from the registered digits; scanning from the top, digits
    // stay blank until the first nonzero one, and digit 0 is always shown.
    always_comb begin
        HEX  = '1;
        lead = 1'b1;
        dig  = '0;
        for (int i = ND-1; i >= 0; i--) begin
            dig = bcd_q[4*i +: 4];
            if (dig != 4'd0 || i == 0) begin
                lead = 1'b0;
            end
            if (!lead) begin
                HEX[8*i +: 8] = seg7(dig);
            end
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign bcd    = bcd_q;

endmodule
